// File: rtl/seq_det_pkg.sv
// Shared types and reset-config constants for the serial pattern detector.
package seq_det_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Config loaded by reset: pattern 0, length 1, unlimited matches.
    localparam int unsigned RstCfgPattern = 0;
    localparam int unsigned RstCfgLen     = 1;
    localparam int unsigned RstCfgLimit   = 0;

endpackage

// File: rtl/seq_det_core.sv
// Shift register, fill counter and length-masked pattern compare.
// Build option: define SEQ_DET_OVERLAP_EN for overlapping detection; otherwise a hit
// clears the fill count so the next match needs len fresh bits.
module seq_det_core #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    localparam logic [LEN_W-1:0] FillMax = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] shreg_q, shreg_next, mask;
    logic [LEN_W-1:0]   fill_q, fill_next;

    // Next shift/fill values and the compare over the low len bits.
    always_comb begin
        shreg_next = {shreg_q[MAX_LEN-2:0], x};
        fill_next  = (fill_q == FillMax) ? fill_q : fill_q + LEN_W'(1);
        mask       = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (i < int'(len));
        end
        hit = shift_en && (fill_next >= len) && ((shreg_next & mask) == (pattern & mask));
    end

    // Shift register and fill count; only accepted bits advance them.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shreg_q <= '0;
            fill_q  <= '0;
        end else if (shift_en) begin
            shreg_q <= shreg_next;
`ifdef SEQ_DET_OVERLAP_EN
            fill_q  <= fill_next;
`else
            fill_q  <= hit ? '0 : fill_next;
`endif
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern detector: config port, arm/stop FSM and match counter.
// Build option: SEQ_DET_OVERLAP_EN (see seq_det_core) selects overlapping detection.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_limit,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               x_valid,
    input  logic               x,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   lim_q, lim_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               match_q, match_d;
    logic               err_q, err_d;
    logic               len_ok, arm, shift_en, hit;

    assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    // stop wins over start and over a bit arriving in the same cycle.
    assign arm      = start && !stop && (state_q == StIdle || state_q == StDone);
    assign shift_en = (state_q == StArmed) && x_valid && !stop;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    seq_det_core #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clear    (arm),
        .x        (x),
        .pattern  (pat_q),
        .len      (len_q),
        .hit      (hit)
    );

    // Next-state, config latch and counter update.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    if (len_ok) begin
                        pat_d = cfg_pattern;
                        len_d = cfg_len;
                        lim_d = cfg_limit;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StArmed: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (hit) begin
                    match_d = 1'b1;
                    cnt_d   = cnt_inc;
                    if (lim_q != '0 && cnt_inc == lim_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (stop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (arm) begin
            state_d = StArmed;
            cnt_d   = '0;
        end
    end

    // State, config and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pat_q   <= MAX_LEN'(RstCfgPattern);
            len_q   <= LEN_W'(RstCfgLen);
            lim_q   <= CNT_W'(RstCfgLimit);
            cnt_q   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready = (state_q == StIdle);
    assign busy      = (state_q == StArmed);
    assign done      = (state_q == StDone);
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed vector table plus randomized traffic against a
// queue-based reference model. Honours SEQ_DET_OVERLAP_EN the same way as the RTL.
module tb_seq_det_ctrl;

`ifdef SEQ_DET_OVERLAP_EN
    localparam int OVL = 1;
`else
    localparam int OVL = 0;
`endif
    localparam int MAXL = 8;

    typedef struct {
        logic       rst, cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic [7:0] lim;
        logic       st, sp, xv, xb;
        logic       e_match;
        logic [7:0] e_cnt;
        logic       e_busy, e_done, e_err;
    } vec_t;

    logic       clk, rst, cfg_valid, cfg_ready, cfg_err, start, stop, x_valid, x;
    logic       match, busy, done;
    logic [7:0] cfg_pattern, cfg_limit, match_cnt;
    logic [3:0] cfg_len;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the accepted-bit history since the last arm (or hit).
    int         m_st;  // 0 idle, 1 armed, 2 done
    logic [7:0] m_pat;
    int         m_len, m_lim, m_cnt;
    bit         m_match, m_err;
    int         hist[$];

    vec_t tbl[$];

    seq_det_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_limit   (cfg_limit),
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .x_valid     (x_valid),
        .x           (x),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, cv, pat, len, lim, st, sp, xv, xb,
                                input int em, ec, eb, ed, ee);
        vec_t v;
        v.rst = r[0]; v.cv = cv[0]; v.pat = pat[7:0]; v.len = len[3:0]; v.lim = lim[7:0];
        v.st = st[0]; v.sp = sp[0]; v.xv = xv[0]; v.xb = xb[0];
        v.e_match = em[0]; v.e_cnt = ec[7:0]; v.e_busy = eb[0]; v.e_done = ed[0];
        v.e_err = ee[0];
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input vec_t v);
        bit hit;
        if (v.rst) begin
            m_st = 0; m_pat = 8'h00; m_len = 1; m_lim = 0; m_cnt = 0;
            m_match = 0; m_err = 0;
            hist.delete();
            return;
        end
        m_match = 0;
        m_err   = 0;
        case (m_st)
            0: begin
                if (v.cv) begin
                    if (v.len >= 1 && int'(v.len) <= MAXL) begin
                        m_pat = v.pat; m_len = int'(v.len); m_lim = int'(v.lim);
                    end else begin
                        m_err = 1;
                    end
                end
                if (v.st && !v.sp) begin
                    m_st = 1; m_cnt = 0; hist.delete();
                end
            end
            1: begin
                if (v.sp) begin
                    m_st = 0;
                end else if (v.xv) begin
                    hist.push_back(int'(v.xb));
                    if (hist.size() > MAXL) void'(hist.pop_front());
                    hit = (hist.size() >= m_len);
                    if (hit) begin
                        for (int k = 0; k < m_len; k++) begin
                            if (hist[hist.size() - m_len + k] != int'(m_pat[m_len - 1 - k]))
                                hit = 0;
                        end
                    end
                    if (hit) begin
                        m_match = 1;
                        if (m_cnt < 255) m_cnt++;
                        if (m_lim != 0 && m_cnt == m_lim) m_st = 2;
                        if (OVL == 0) hist.delete();
                    end
                end
            end
            default: begin
                if (v.sp) begin
                    m_st = 0;
                end else if (v.st) begin
                    m_st = 1; m_cnt = 0; hist.delete();
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs, step the model, then sample after the edge.
    task automatic apply(input vec_t v, input bit use_exp, input string tag);
        rst = v.rst; cfg_valid = v.cv; cfg_pattern = v.pat; cfg_len = v.len;
        cfg_limit = v.lim; start = v.st; stop = v.sp; x_valid = v.xv; x = v.xb;
        model_step(v);
        @(posedge clk);
        #1;
        chk({tag, " cfg_ready"}, int'(cfg_ready), int'(m_st == 0));
        chk({tag, " cfg_err"},   int'(cfg_err),   int'(m_err));
        chk({tag, " match"},     int'(match),     int'(m_match));
        chk({tag, " match_cnt"}, int'(match_cnt), m_cnt);
        chk({tag, " busy"},      int'(busy),      int'(m_st == 1));
        chk({tag, " done"},      int'(done),      int'(m_st == 2));
        if (use_exp) begin
            chk({tag, " tbl match"},     int'(match),     int'(v.e_match));
            chk({tag, " tbl match_cnt"}, int'(match_cnt), int'(v.e_cnt));
            chk({tag, " tbl busy"},      int'(busy),      int'(v.e_busy));
            chk({tag, " tbl done"},      int'(done),      int'(v.e_done));
            chk({tag, " tbl cfg_err"},   int'(cfg_err),   int'(v.e_err));
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_limit = 0;
        start = 0; stop = 0; x_valid = 0; x = 0;

        //            rst cv pat   len lim st sp xv xb   em      ec       eb      ed ee
        // Reset, then 101/len3/unlimited on stream 1,0,1,0,1.
        tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 0, 0,  0, 0,       0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h05, 3, 0, 0, 0, 0, 0,  0, 0,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  1, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0,  0, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  OVL, 1+OVL, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 1, 0, 0,  0, 1+OVL,   0, 0, 0));
        // Pattern 11, len 2, limit 2 on stream 1,1,1,1,1.
        tbl.push_back(mk(0, 1, 8'h03, 2, 2, 0, 0, 0, 0,  0, 1+OVL,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  1, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  OVL, 1+OVL, 1-OVL, OVL, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  1-OVL, 2,   0, 1, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  0, 2,       0, 1, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 1, 0, 0,  0, 2,       0, 0, 0));
        // Rejected configs (len 0, len MAXL+1), then a config offered while armed.
        tbl.push_back(mk(0, 1, 8'hff, 0, 0, 0, 0, 0, 0,  0, 2,       0, 0, 1));
        tbl.push_back(mk(0, 1, 8'hff, 9, 0, 0, 0, 0, 0,  0, 2,       0, 0, 1));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0,  0, 2,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 1, 1, 0, 0, 1, 1,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  1, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 1, 0, 0,  0, 1,       0, 0, 0));
        // stop together with a completing bit.
        tbl.push_back(mk(0, 1, 8'h05, 3, 0, 0, 0, 0, 0,  0, 1,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  1, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  0, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0,  0, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 1, 1, 1,  0, 1,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0,  0, 1,       0, 0, 0));
        // x_valid gaps between the bits of 101.
        tbl.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 1,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  1, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0,  0, 1,       1, 0, 0));
        // Reset mid-stream overrides an in-flight match; reset config is 0/len1.
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  0, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0,  0, 1,       1, 0, 0));
        tbl.push_back(mk(1, 0, 0,     0, 0, 0, 0, 1, 1,  0, 0,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 0, 0,  0, 0,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 1, 0, 0, 0,  0, 0,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0,  1, 1,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 0,  1, 2,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 0, 1, 1,  0, 2,       1, 0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0, 1, 0, 0,  0, 2,       0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 1'b1, $sformatf("row%0d", i));
        end

        // Randomized traffic; short patterns are favoured so matches actually occur.
        for (int c = 0; c < 4000; c++) begin
            v.rst = ($urandom_range(0, 299) == 0);
            v.cv  = ($urandom_range(0, 3) == 0);
            v.pat = 8'($urandom);
            v.len = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(1, 3))
                                                : 4'($urandom_range(0, 9));
            v.lim = 8'($urandom_range(0, 4));
            v.st  = ($urandom_range(0, 7) == 0);
            v.sp  = ($urandom_range(0, 29) == 0);
            v.xv  = ($urandom_range(0, 3) != 0);
            v.xb  = 1'($urandom);
            v.e_match = 0; v.e_cnt = 0; v.e_busy = 0; v.e_done = 0; v.e_err = 0;
            apply(v, 1'b0, $sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
